uart_transmitter: RTL and testbench



---
 rtl/uart_transmitter.sv | 186 ++++++++++++++++++
 tb/tb_uart_transmitter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, WIDTH data bits LSB-first, optional parity, STOP_BITS stop bits.
// Define UART_TX_BUFFER_EN to compile in a one-word holding buffer for zero-gap back-to-back frames.
module uart_transmitter #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int WIDTH     = 8,
  parameter int PARITY    = 1,
  parameter int STOP_BITS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             dataValid,
  output logic             txReady,
  output logic             uartTx,
  output logic             txBusy,
  output logic             txDone,
  output logic [2:0]       fsmState
);

  localparam int BAUD_COUNT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W      = (BAUD_COUNT > 1) ? $clog2(BAUD_COUNT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST    = CNT_W'(BAUD_COUNT - 1);
  localparam logic [CNT_W-1:0] BAUD_PRELAST = CNT_W'(BAUD_COUNT - 2);
  localparam logic [3:0] DATA_LAST = 4'(WIDTH - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

`ifdef UART_TX_BUFFER_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif

  if (WIDTH < 5 || WIDTH > 9) begin : g_bad_width
    $error("uart_transmitter: WIDTH must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_transmitter: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_transmitter: STOP_BITS must be 1 or 2");
  end
  if (BAUD_COUNT < 2) begin : g_bad_baud
    $error("uart_transmitter: CLK_FREQ / BAUD_RATE must be at least 2");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PAR    = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] baudCnt;
  logic [3:0]       bitCnt;
  logic [WIDTH-1:0] shift;
  logic             parityBit;
  logic [WIDTH-1:0] bufData;
  logic             bufFull;
  logic             accept;
  logic             baudWrap;

  // Handshake: a word transfers on every rising edge where dataValid && txReady;
  // txReady never depends on dataValid, and dataIn is ignored on all other edges.
`ifdef UART_TX_BUFFER_EN
  assign txReady = !bufFull;
`else
  assign txReady = (state == IDLE);
`endif

  assign accept   = dataValid && txReady;
  assign baudWrap = (baudCnt == BAUD_LAST);
  assign fsmState = state;

  function automatic logic calcParity(input logic [WIDTH-1:0] d);
    return (PARITY == 2) ? ~^d : ^d;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      baudCnt   <= '0;
      bitCnt    <= '0;
      shift     <= '0;
      parityBit <= 1'b0;
      bufData   <= '0;
      bufFull   <= 1'b0;
      uartTx    <= 1'b1;
      txBusy    <= 1'b0;
      txDone    <= 1'b0;
    end else begin
      txDone <= 1'b0;
      if (BUF_EN && accept && state != IDLE) begin
        bufData <= dataIn;
        bufFull <= 1'b1;
      end
      case (state)
        IDLE: begin
          baudCnt <= '0;
          bitCnt  <= '0;
          uartTx  <= 1'b1;
          if (accept) begin
            state     <= START;
            shift     <= dataIn;
            parityBit <= calcParity(dataIn);
            uartTx    <= 1'b0;
            txBusy    <= 1'b1;
          end
        end
        START: begin
          if (baudWrap) begin
            baudCnt <= '0;
            state   <= DATA;
            uartTx  <= shift[0];
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
        DATA: begin
          if (baudWrap) begin
            baudCnt <= '0;
            if (bitCnt == DATA_LAST) begin
              bitCnt <= '0;
              if (PARITY != 0) begin
                state  <= PAR;
                uartTx <= parityBit;
              end else begin
                state  <= STOP;
                uartTx <= 1'b1;
              end
            end else begin
              bitCnt <= bitCnt + 1'b1;
              shift  <= shift >> 1;
              uartTx <= shift[1];
            end
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
        PAR: begin
          if (baudWrap) begin
            baudCnt <= '0;
            bitCnt  <= '0;
            state   <= STOP;
            uartTx  <= 1'b1;
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
        STOP: begin
          if (baudWrap) begin
            baudCnt <= '0;
            if (bitCnt == STOP_LAST) begin
              bitCnt <= '0;
              // A word accepted in this very cycle is already pending and chains on directly.
              if (BUF_EN && (bufFull || accept)) begin
                state     <= START;
                shift     <= bufFull ? bufData : dataIn;
                parityBit <= calcParity(bufFull ? bufData : dataIn);
                bufFull   <= 1'b0;
                uartTx    <= 1'b0;
              end else begin
                state  <= IDLE;
                txBusy <= 1'b0;
                uartTx <= 1'b1;
              end
            end else begin
              bitCnt <= bitCnt + 1'b1;
            end
          end else begin
            baudCnt <= baudCnt + 1'b1;
            if (baudCnt == BAUD_PRELAST && bitCnt == STOP_LAST) txDone <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          uartTx <= 1'b1;
          txBusy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: three instances (even/1 stop, odd/1 stop, none/2 stop)
// at BAUD_COUNT = 10; frame timing, line values, done pulse, handshake and reset behaviour.
module tb_uart_transmitter;

  localparam int BC = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] din0 = '0, din1 = '0, din2 = '0;
  logic dv0 = 1'b0, dv1 = 1'b0, dv2 = 1'b0;
  logic rdy0, tx0, busy0, done0;
  logic rdy1, tx1, busy1, done1;
  logic rdy2, tx2, busy2, done2;
  logic [2:0] st0, st1, st2;

  uart_transmitter #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .WIDTH(8), .PARITY(1), .STOP_BITS(1))
    dut_even (.clk(clk), .reset(reset), .dataIn(din0), .dataValid(dv0), .txReady(rdy0),
              .uartTx(tx0), .txBusy(busy0), .txDone(done0), .fsmState(st0));
  uart_transmitter #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .WIDTH(8), .PARITY(2), .STOP_BITS(1))
    dut_odd (.clk(clk), .reset(reset), .dataIn(din1), .dataValid(dv1), .txReady(rdy1),
             .uartTx(tx1), .txBusy(busy1), .txDone(done1), .fsmState(st1));
  uart_transmitter #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .WIDTH(8), .PARITY(0), .STOP_BITS(2))
    dut_none (.clk(clk), .reset(reset), .dataIn(din2), .dataValid(dv2), .txReady(rdy2),
              .uartTx(tx2), .txBusy(busy2), .txDone(done2), .fsmState(st2));

  int sel = 0;
  logic selTx, selReady, selBusy, selDone;
  logic [2:0] selState;
  always_comb begin
    case (sel)
      1:       {selTx, selReady, selBusy, selDone, selState} = {tx1, rdy1, busy1, done1, st1};
      2:       {selTx, selReady, selBusy, selDone, selState} = {tx2, rdy2, busy2, done2, st2};
      default: {selTx, selReady, selBusy, selDone, selState} = {tx0, rdy0, busy0, done0, st0};
    endcase
  end

  int checks = 0;
  int errors = 0;

  logic lineLog  [0:299];
  logic doneLog  [0:299];
  logic busyLog  [0:299];
  logic readyLog [0:299];

  // ---------------- driver tasks ----------------
  task automatic drive(input int unit, input logic [7:0] d, input logic v);
    case (unit)
      1:       begin din1 = d; dv1 = v; end
      2:       begin din2 = d; dv2 = v; end
      default: begin din0 = d; dv0 = v; end
    endcase
  endtask

  // Returns positioned in cycle T+1 of the accept edge T.
  task automatic start_frame(input int unit, input logic [7:0] d, input logic keep);
    int w;
    sel = unit;
    drive(unit, d, 1'b1);
    w = 0;
    while (!selReady && w < 500) begin
      @(posedge clk); #1;
      w++;
    end
    checks++;
    if (w >= 500) begin
      errors++;
      $display("FAIL accept_timeout: txReady still %b after %0d cycles, required 1", selReady, w);
    end
    @(posedge clk); #1;
    if (!keep) drive(unit, 8'h00, 1'b0);
  endtask

  // Records cycles lo..hi (one sample per cycle, #1 after the edge that starts it).
  task automatic capture(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      lineLog[k]  = selTx;
      doneLog[k]  = selDone;
      busyLog[k]  = selBusy;
      readyLog[k] = selReady;
      @(posedge clk); #1;
    end
  endtask

  // ---------------- small reference helpers ----------------
  function automatic logic [10:0] bad_bits(input logic [10:0] expv, input int base);
    logic [10:0] m;
    m = '0;
    for (int b = 0; b < 11; b++)
      for (int c = 1; c <= BC; c++)
        if (lineLog[base + b*BC + c] !== expv[b]) m[b] = 1'b1;
    return m;
  endfunction

  function automatic int done_pos(input int lo, input int hi);
    int n, p;
    n = 0; p = -1;
    for (int k = lo; k <= hi; k++)
      if (doneLog[k] === 1'b1) begin n++; p = k; end
    return (n == 1) ? p : -1;
  endfunction

  function automatic logic [7:0] decode(input int base);
    logic [7:0] d;
    for (int j = 0; j < 8; j++) d[j] = lineLog[base + (1 + j)*BC + BC/2];
    return d;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    sel = 0;
    checks++; if (tx0 !== 1'b1)    begin errors++; $display("FAIL reset_tx: got %b, required 1", tx0); end
    checks++; if (rdy0 !== 1'b1)   begin errors++; $display("FAIL reset_ready: got %b, required 1", rdy0); end
    checks++; if (busy0 !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b, required 0", busy0); end
    checks++; if (done0 !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b, required 0", done0); end
    checks++; if (st0 !== 3'd0)    begin errors++; $display("FAIL reset_state: got %0d, required 0", st0); end
    checks++; if ({tx1, tx2} !== 2'b11) begin errors++; $display("FAIL reset_tx_others: got %b, required 11", {tx1, tx2}); end
  endtask

  task automatic test_even_parity();
    logic [10:0] m;
    logic [7:0] d;
    logic rdyBad;
    int p;
    start_frame(0, 8'hA7, 1'b0);
    capture(1, 112);
    m = bad_bits(11'b1_1_10100111_0, 0);
    checks++; if (m !== 11'd0) begin errors++; $display("FAIL even_line: wrong bit mask %b, required 0", m); end
    p = done_pos(1, 112);
    checks++; if (p !== 110) begin errors++; $display("FAIL even_done_pos: got %0d, required 110", p); end
    checks++;
    if ({busyLog[1], busyLog[110], busyLog[111], lineLog[111]} !== 4'b1101) begin
      errors++; $display("FAIL even_busy_end: busy1/busy110/busy111/line111 = %b, required 1101",
                         {busyLog[1], busyLog[110], busyLog[111], lineLog[111]});
    end
    rdyBad = 1'b0;
`ifdef UART_TX_BUFFER_EN
    for (int k = 1; k <= 111; k++) if (readyLog[k] !== 1'b1) rdyBad = 1'b1;
`else
    for (int k = 1; k <= 110; k++) if (readyLog[k] !== 1'b0) rdyBad = 1'b1;
    if (readyLog[111] !== 1'b1) rdyBad = 1'b1;
`endif
    checks++; if (rdyBad !== 1'b0) begin errors++; $display("FAIL even_ready: txReady wrong during/after frame, got bad=%b required 0", rdyBad); end
    d = decode(0);
    checks++; if (d !== 8'hA7) begin errors++; $display("FAIL even_loopback_data: got %h, required a7", d); end
    checks++; if ((^d ^ lineLog[9*BC + BC/2]) !== 1'b0) begin
      errors++; $display("FAIL even_loopback_parity_error: got 1, required 0");
    end
  endtask

  task automatic test_odd_parity();
    logic [10:0] m;
    int p;
    start_frame(1, 8'h55, 1'b0);
    capture(1, 112);
    checks++; if (lineLog[95] !== 1'b1) begin errors++; $display("FAIL odd_parity_bit: got %b, required 1", lineLog[95]); end
    m = bad_bits(11'b1_1_01010101_0, 0);
    checks++; if (m !== 11'd0) begin errors++; $display("FAIL odd_line: wrong bit mask %b, required 0", m); end
    p = done_pos(1, 112);
    checks++; if (p !== 110) begin errors++; $display("FAIL odd_done_pos: got %0d, required 110", p); end
  endtask

  task automatic test_no_parity_two_stop();
    logic [10:0] m;
    int p;
    start_frame(2, 8'h55, 1'b0);
    capture(1, 112);
    m = bad_bits(11'b1_1_01010101_0, 0);
    checks++; if (m !== 11'd0) begin errors++; $display("FAIL nopar_line: wrong bit mask %b, required 0", m); end
    p = done_pos(1, 112);
    checks++; if (p !== 110) begin errors++; $display("FAIL nopar_done_pos: got %0d, required 110", p); end
    checks++; if ({busyLog[110], busyLog[111]} !== 2'b10) begin
      errors++; $display("FAIL nopar_length: busy110/busy111 = %b, required 10", {busyLog[110], busyLog[111]});
    end
    sel = 0;
  endtask

  task automatic test_reset_mid_frame();
    logic [10:0] m;
    logic quiet;
    int p;
    start_frame(0, 8'hFF, 1'b0);
    capture(1, 34);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if ({tx0, busy0, rdy0, st0} !== {3'b101, 3'd0}) begin
      errors++; $display("FAIL midreset_state: tx/busy/ready/state = %b/%b/%b/%0d, required 1/0/1/0", tx0, busy0, rdy0, st0);
    end
    capture(1, 120);
    quiet = 1'b0;
    for (int k = 1; k <= 120; k++) if (doneLog[k] !== 1'b0 || lineLog[k] !== 1'b1) quiet = 1'b1;
    checks++; if (quiet !== 1'b0) begin errors++; $display("FAIL midreset_no_done: done or line activity after reset, got 1 required 0"); end
    start_frame(0, 8'h3C, 1'b0);
    capture(1, 112);
    m = bad_bits(11'b1_0_00111100_0, 0);
    checks++; if (m !== 11'd0) begin errors++; $display("FAIL midreset_next_line: wrong bit mask %b, required 0", m); end
    p = done_pos(1, 112);
    checks++; if (p !== 110) begin errors++; $display("FAIL midreset_next_done: got %0d, required 110", p); end
  endtask

`ifndef UART_TX_BUFFER_EN
  task automatic test_back_to_back();
    logic [10:0] m;
    logic rdyBad;
    start_frame(0, 8'h00, 1'b1);
    drive(0, 8'hFF, 1'b1);
    capture(1, 221);
    drive(0, 8'h00, 1'b0);
    capture(222, 230);
    rdyBad = 1'b0;
    for (int k = 1; k <= 110; k++) if (readyLog[k] !== 1'b0) rdyBad = 1'b1;
    checks++; if (rdyBad !== 1'b0) begin errors++; $display("FAIL b2b_ready_low: txReady high mid-frame, got bad=1 required 0"); end
    checks++; if ({readyLog[111], lineLog[111], lineLog[112]} !== 3'b110) begin
      errors++; $display("FAIL b2b_gap: ready111/line111/line112 = %b, required 110", {readyLog[111], lineLog[111], lineLog[112]});
    end
    m = bad_bits(11'b1_0_00000000_0, 0);
    checks++; if (m !== 11'd0) begin errors++; $display("FAIL b2b_first_line: wrong bit mask %b, required 0", m); end
    m = bad_bits(11'b1_0_11111111_0, 111);
    checks++; if (m !== 11'd0) begin errors++; $display("FAIL b2b_second_line: wrong bit mask %b, required 0", m); end
    checks++; if ({doneLog[110], doneLog[221], doneLog[111], lineLog[222]} !== 4'b1101) begin
      errors++; $display("FAIL b2b_done: done110/done221/done111/line222 = %b, required 1101",
                         {doneLog[110], doneLog[221], doneLog[111], lineLog[222]});
    end
  endtask

  task automatic test_ignored_valid();
    logic [10:0] m;
    logic extra;
    int p;
    start_frame(0, 8'h81, 1'b0);
    capture(1, 20);
    drive(0, 8'h5A, 1'b1);
    capture(21, 23);
    drive(0, 8'h00, 1'b0);
    capture(24, 140);
    m = bad_bits(11'b1_0_10000001_0, 0);
    checks++; if (m !== 11'd0) begin errors++; $display("FAIL ignore_line: wrong bit mask %b, required 0", m); end
    p = done_pos(1, 140);
    checks++; if (p !== 110) begin errors++; $display("FAIL ignore_done: got %0d, required 110", p); end
    extra = 1'b0;
    for (int k = 111; k <= 140; k++) if (lineLog[k] !== 1'b1 || busyLog[k] !== 1'b0) extra = 1'b1;
    checks++; if (extra !== 1'b0) begin errors++; $display("FAIL ignore_no_extra: extra frame activity, got 1 required 0"); end
  endtask
`else
  task automatic test_buffered();
    logic [10:0] m;
    start_frame(0, 8'h12, 1'b0);
    drive(0, 8'h34, 1'b1);
    capture(1, 1);
    drive(0, 8'h00, 1'b0);
    capture(2, 225);
    checks++; if ({readyLog[1], readyLog[2]} !== 2'b10) begin
      errors++; $display("FAIL buf_ready_drop: ready1/ready2 = %b, required 10", {readyLog[1], readyLog[2]});
    end
    checks++; if ({doneLog[110], lineLog[111], readyLog[111]} !== 3'b101) begin
      errors++; $display("FAIL buf_zero_gap: done110/line111/ready111 = %b, required 101", {doneLog[110], lineLog[111], readyLog[111]});
    end
    m = bad_bits(11'b1_0_00010010_0, 0);
    checks++; if (m !== 11'd0) begin errors++; $display("FAIL buf_first_line: wrong bit mask %b, required 0", m); end
    m = bad_bits(11'b1_1_00110100_0, 110);
    checks++; if (m !== 11'd0) begin errors++; $display("FAIL buf_second_line: wrong bit mask %b, required 0", m); end
    checks++; if ({doneLog[220], lineLog[221], busyLog[221]} !== 3'b110) begin
      errors++; $display("FAIL buf_second_done: done220/line221/busy221 = %b, required 110", {doneLog[220], lineLog[221], busyLog[221]});
    end
  endtask
`endif

  task automatic test_idle_line();
    logic bad;
    sel = 0;
    capture(1, 200);
    bad = 1'b0;
    for (int k = 1; k <= 200; k++) if (lineLog[k] !== 1'b1 || busyLog[k] !== 1'b0) bad = 1'b1;
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL idle_line: line not steady high, got bad=1 required 0"); end
  endtask

  initial begin
    test_reset();
    test_even_parity();
    test_odd_parity();
    test_no_parity_two_stop();
    test_reset_mid_frame();
`ifndef UART_TX_BUFFER_EN
    test_back_to_back();
    test_ignored_valid();
`else
    test_buffered();
`endif
    test_idle_line();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
